// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch/decode types, constants and instruction length helper
package cpu_pkg;

  typedef enum logic [1:0] {
    S_OP    = 2'd0,
    S_IMM   = 2'd1,
    S_VALID = 2'd2
  } fetch_state_t;

  localparam logic [1:0] OPC_TWO_BYTE_PREFIX = 2'b11;

  // Opcodes whose top two bits match the prefix carry an immediate byte.
  function automatic logic is_two_byte(input logic [7:0] opcode);
    return opcode[7:6] == OPC_TWO_BYTE_PREFIX;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, ROM sequencing and instruction handoff to decode
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_en,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic       ins_valid,
  input  logic       ins_ready,
  output logic [7:0] ins_opcode,
  output logic [7:0] ins_imm,
  output logic       ins_two,
  output logic [7:0] ins_pc
);

  fetch_state_t state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [7:0]   imm_q, imm_d;
  logic         two_q, two_d;
  logic [7:0]   ipc_q, ipc_d;

  // Next-state logic: redirect overrides everything; a handshake in the same
  // cycle needs no extra work since decode has already taken the instruction.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    two_d    = two_q;
    ipc_d    = ipc_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      state_d = S_OP;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_OP: begin
          if (fetch_en) begin
            opcode_d = rom_data;
            ipc_d    = pc_q;
            pc_d     = pc_q + 8'd1;
            two_d    = is_two_byte(rom_data);
            if (is_two_byte(rom_data)) begin
              state_d = S_IMM;
            end else begin
              imm_d   = 8'h00;
              state_d = S_VALID;
              valid_d = 1'b1;
            end
          end
        end
        S_IMM: begin
          imm_d   = rom_data;
          pc_d    = pc_q + 8'd1;
          state_d = S_VALID;
          valid_d = 1'b1;
        end
        S_VALID: begin
          if (ins_ready) begin
            state_d = S_OP;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = S_OP;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset drops any partial instruction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_OP;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      opcode_q <= 8'h00;
      imm_q    <= 8'h00;
      two_q    <= 1'b0;
      ipc_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      two_q    <= two_d;
      ipc_q    <= ipc_d;
    end
  end

  assign rom_addr   = pc_q;
  assign ins_valid  = valid_q;
  assign ins_opcode = opcode_q;
  assign ins_imm    = imm_q;
  assign ins_two    = two_q;
  assign ins_pc     = ipc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized self-checking bench for fetch_unit
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetch_en = 1'b1;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       ins_valid;
  logic       ins_ready = 1'b1;
  logic [7:0] ins_opcode;
  logic [7:0] ins_imm;
  logic       ins_two;
  logic [7:0] ins_pc;

  logic [7:0] rom [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_unit #(.RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_opcode  (ins_opcode),
    .ins_imm     (ins_imm),
    .ins_two     (ins_two),
    .ins_pc      (ins_pc)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ins(input string tag, input logic [7:0] op, input logic [7:0] imm,
                           input logic two, input logic [7:0] pc);
    check_eq({tag, "_valid"}, 16'(ins_valid), 16'd1);
    check_eq({tag, "_opcode"}, 16'(ins_opcode), 16'(op));
    check_eq({tag, "_imm"}, 16'(ins_imm), 16'(imm));
    check_eq({tag, "_two"}, 16'(ins_two), 16'(two));
    check_eq({tag, "_pc"}, 16'(ins_pc), 16'(pc));
  endtask

  logic [7:0] model_pc;
  logic [7:0] exp_op, exp_imm;
  logic       exp_two;
  logic       hold_prev;
  logic [7:0] prev_op, prev_imm, prev_pc, prev_addr;
  logic       prev_two;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h10; rom[8'h01] = 8'hC5; rom[8'h02] = 8'h3A; rom[8'h03] = 8'h20;
    rom[8'h04] = 8'hC1; rom[8'h05] = 8'h55; rom[8'h80] = 8'h11; rom[8'h90] = 8'h12;
    rom[8'hFF] = 8'hC0;

    #1;
    check_eq("rst_valid", 16'(ins_valid), 16'd0);
    check_eq("rst_addr", 16'(rom_addr), 16'h00);
    check_eq("rst_opcode", 16'(ins_opcode), 16'h00);
    check_eq("rst_imm", 16'(ins_imm), 16'h00);
    check_eq("rst_two", 16'(ins_two), 16'd0);
    check_eq("rst_pc", 16'(ins_pc), 16'h00);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // one-byte opcode straight after reset
    @(negedge clk);
    check_ins("first", 8'h10, 8'h00, 1'b0, 8'h00);
    check_eq("first_addr", 16'(rom_addr), 16'h01);
    @(negedge clk);
    check_eq("after_hs_valid", 16'(ins_valid), 16'd0);
    check_eq("after_hs_addr", 16'(rom_addr), 16'h01);

    // two-byte opcode: valid two edges after the opcode fetch
    @(negedge clk);
    check_eq("imm_phase_valid", 16'(ins_valid), 16'd0);
    check_eq("imm_phase_addr", 16'(rom_addr), 16'h02);
    @(negedge clk);
    check_ins("two", 8'hC5, 8'h3A, 1'b1, 8'h01);
    check_eq("two_addr", 16'(rom_addr), 16'h03);

    // backpressure
    ins_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_ins("bp", 8'hC5, 8'h3A, 1'b1, 8'h01);
      check_eq("bp_addr", 16'(rom_addr), 16'h03);
    end
    ins_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_rel_valid", 16'(ins_valid), 16'd0);
    check_eq("bp_rel_addr", 16'(rom_addr), 16'h03);
    @(negedge clk);
    check_ins("next", 8'h20, 8'h00, 1'b0, 8'h03);
    check_eq("next_addr", 16'(rom_addr), 16'h04);

    // redirect during the immediate fetch
    @(negedge clk);
    check_eq("pre_c1_valid", 16'(ins_valid), 16'd0);
    @(negedge clk);
    check_eq("c1_imm_addr", 16'(rom_addr), 16'h05);
    redirect = 1'b1; redirect_pc = 8'h80;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("redir_valid", 16'(ins_valid), 16'd0);
    check_eq("redir_addr", 16'(rom_addr), 16'h80);
    @(negedge clk);
    check_ins("redir_tgt", 8'h11, 8'h00, 1'b0, 8'h80);

    // redirect coincident with a handshake: accepted once, not re-presented
    redirect = 1'b1; redirect_pc = 8'h90;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("co_valid", 16'(ins_valid), 16'd0);
    check_eq("co_addr", 16'(rom_addr), 16'h90);
    @(negedge clk);
    check_ins("co_tgt", 8'h12, 8'h00, 1'b0, 8'h90);

    // wrap: two-byte opcode at FF takes its immediate from 00
    rom[8'h00] = 8'h7E;
    redirect = 1'b1; redirect_pc = 8'hFF;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("wrap_addr0", 16'(rom_addr), 16'hFF);
    @(negedge clk);
    check_eq("wrap_addr1", 16'(rom_addr), 16'h00);
    @(negedge clk);
    check_ins("wrap", 8'hC0, 8'h7E, 1'b1, 8'hFF);
    check_eq("wrap_addr2", 16'(rom_addr), 16'h01);

    // fetch disabled in S_OP
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("dis_valid", 16'(ins_valid), 16'd0);
      check_eq("dis_addr", 16'(rom_addr), 16'h01);
    end
    fetch_en = 1'b1;
    @(negedge clk);
    check_eq("en_addr", 16'(rom_addr), 16'h02);

    // asynchronous reset in S_IMM, between clock edges
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 16'(ins_valid), 16'd0);
    check_eq("arst_addr", 16'(rom_addr), 16'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_ins("post_rst", 8'h7E, 8'h00, 1'b0, 8'h00);

    // randomized run against a transaction-level model
    rst = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    fetch_en = 1'b1; ins_ready = 1'b1; redirect = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_pc = 8'h00;
    hold_prev = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (hold_prev) begin
        check_eq("r_hold_valid", 16'(ins_valid), 16'd1);
        check_eq("r_hold_op", 16'(ins_opcode), 16'(prev_op));
        check_eq("r_hold_imm", 16'(ins_imm), 16'(prev_imm));
        check_eq("r_hold_two", 16'(ins_two), 16'(prev_two));
        check_eq("r_hold_pc", 16'(ins_pc), 16'(prev_pc));
        check_eq("r_hold_addr", 16'(rom_addr), 16'(prev_addr));
      end
      fetch_en    = ($urandom_range(0, 9) < 8);
      ins_ready   = ($urandom_range(0, 9) < 6);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 8'($urandom);
      if (ins_valid && ins_ready) begin
        exp_op  = rom[model_pc];
        exp_two = (exp_op >= 8'hC0);
        exp_imm = exp_two ? rom[8'(model_pc + 8'd1)] : 8'h00;
        check_ins("r_acc", exp_op, exp_imm, exp_two, model_pc);
        model_pc = model_pc + (exp_two ? 8'd2 : 8'd1);
        check_eq("r_acc_addr", 16'(rom_addr), 16'(model_pc));
      end
      hold_prev = ins_valid && !ins_ready && !redirect;
      prev_op = ins_opcode; prev_imm = ins_imm; prev_two = ins_two;
      prev_pc = ins_pc; prev_addr = rom_addr;
      if (redirect) model_pc = redirect_pc;
    end
    redirect = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the 8-bit CPU. Owns the program counter, drives the address of the combinational program ROM (8-bit address in, 8-bit instruction byte out, same cycle), assembles one- and two-byte instructions, and hands them to decode over a valid/ready handshake. Control flow changes (jumps, branches, reset vector) enter through a redirect port that takes priority over fetching.

## Interface
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `fetch_en`  in  1  when low, no new opcode fetch starts; an in-flight instruction completes.
- `rom_addr`  out  8  ROM address; equals the internal PC register.
- `rom_data`  in  8  ROM byte at `rom_addr`, valid in the same cycle.
- `redirect`  in  1  one-cycle pulse: load PC from `redirect_pc` and discard the current fetch.
- `redirect_pc`  in  8  redirect target.
- `ins_valid`  out  1  instruction outputs are valid.
- `ins_ready`  in  1  decode accepts the instruction when `ins_valid && ins_ready`.
- `ins_opcode`  out  8  opcode byte.
- `ins_imm`  out  8  immediate byte; 8'h00 for one-byte instructions.
- `ins_two`  out  1  1 means a two-byte instruction (opcode plus immediate).
- `ins_pc`  out  8  address of the opcode byte.

## Operation
- Length rule: an opcode with `opcode[7:6] == 2'b11` is two bytes. All other opcodes are one byte.
- States:
  - S_OP: if `fetch_en` is high, latch `ins_opcode <= rom_data` and `ins_pc <= pc`, then `pc <= pc+1`. Go to S_IMM if the opcode is two-byte, else go to S_VALID with `ins_imm <= 0`. If `fetch_en` is low, hold.
  - S_IMM: `ins_imm <= rom_data`, `pc <= pc+1`, go to S_VALID.
  - S_VALID: `ins_valid = 1`. All `ins_*` outputs are stable until the handshake. On handshake go to S_OP.
- `ins_valid` is a registered output and is high only in S_VALID.
- PC arithmetic is modulo 256: 8'hFF+1 = 8'h00. A two-byte opcode at 8'hFF takes its immediate from 8'h00.
- Redirect has highest priority in every state:
  - `pc <= redirect_pc`, state goes to S_OP, and any partially fetched or unaccepted instruction is dropped.
  - `ins_valid` is 0 from the next cycle.
  - If a handshake and a redirect occur in the same cycle, the handshake counts as completed (decode keeps the instruction), then the redirect applies.
  - `redirect` takes effect even when `fetch_en` is low.
- Reset values (asynchronous): `pc = RESET_PC`, state S_OP, `ins_valid = 0`, `ins_opcode = ins_imm = ins_pc = 8'h00`, `ins_two = 0`, so `rom_addr = RESET_PC`.
- Reset mid-instruction discards the partial instruction. Fetch restarts at `RESET_PC` on the first clock edge after `rst` falls.

## Timing
- One-byte instruction: opcode sampled in edge N, `ins_valid` high after edge N. Latency 1 cycle. Back-to-back throughput is 1 instruction per 2 cycles when `ins_ready` is held high.
- Two-byte instruction: latency 2 cycles, throughput 1 per 3 cycles.
- Redirect asserted in cycle N: `rom_addr = redirect_pc` after edge N. Opcode at the target is captured at edge N+1, and `ins_valid` is high after edge N+1 for a one-byte target.
- No combinational path from `ins_ready`, `redirect` or `rom_data` to any output. `rom_addr` is purely registered.

## Structure
- Shared `cpu_pkg` holds:
  - the state enum (`S_OP`, `S_IMM`, `S_VALID`)
  - `OPC_TWO_BYTE_PREFIX = 2'b11`
  - the function `is_two_byte(opcode)`, reused by decode.
- Single module with no sub-module. The PC register and the FSM are small enough to live together.

## Test plan
- Reset: ROM holds 8'h10 at 8'h00, `ins_ready = 1`, `fetch_en = 1` → after reset release `ins_valid` rises after the first edge with opcode 8'h10, `ins_two = 0`, `ins_imm = 8'h00`, `ins_pc = 8'h00`. Next `rom_addr` is 8'h01.
- Two-byte: ROM[8'h01..02] = C5, 3A → `ins_opcode = 8'hC5`, `ins_imm = 8'h3A`, `ins_two = 1`, `ins_pc = 8'h01`. Valid 2 cycles after the opcode fetch starts.
- Backpressure: hold `ins_ready = 0` for 5 cycles while valid → outputs stable and `rom_addr` frozen. Release → one handshake, then the next opcode is fetched.
- Redirect: pulse `redirect` with `redirect_pc = 8'h80` during S_IMM → partial instruction dropped, no valid, next instruction has `ins_pc = 8'h80`. Repeat with redirect coincident with a handshake → the instruction is counted as accepted exactly once.
- Wrap: start at 8'hFF with ROM[FF] = C0 and ROM[00] = 7E → `ins_imm = 8'h7E` and PC ends at 8'h01.
- `fetch_en = 0` in S_OP and asynchronous `rst` in S_IMM → no fetch while disabled. Reset forces `ins_valid = 0` and `rom_addr = RESET_PC` immediately, without a clock edge.
